// File: rtl/lane_frame_pkg.sv
// Shared types and helpers for the lane-indexed packed frame packer.
package lane_frame_pkg;

    localparam int unsigned LANES_DEF  = 4;
    localparam int unsigned LANE_W_DEF = 8;

    // msb carries the beat count, lsb the XOR checksum of written data.
    typedef struct packed {
        logic [7:0]                  msb;
        logic [0:LANES_DEF-1][7:0]   data;
        logic [7:0]                  lsb;
    } lane_frame_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } lane_pack_state_t;

    // Start-of-frame accumulator: every lane erased, count and checksum cleared.
    function automatic lane_frame_t frame_init();
        lane_frame_t f;
        f.msb  = 8'h00;
        f.data = '1;
        f.lsb  = 8'h00;
        return f;
    endfunction

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? 8'hff : (v + 8'h01);
    endfunction

    // Running XOR checksum update.
    function automatic logic [7:0] csum_upd8(input logic [7:0] c, input logic [7:0] d);
        return c ^ d;
    endfunction

endpackage

// File: rtl/lane_frame_packer.sv
// Assembles addressed byte beats into a packed {count, lanes, checksum} frame
// and presents the closed frame downstream over a valid/ready handshake.
module lane_frame_packer
    import lane_frame_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned W     = LANE_W_DEF,
    parameter int unsigned IDX_W = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IDX_W-1:0]       in_addr_i,
    input  logic [W-1:0]           in_data_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [(LANES+2)*W-1:0] out_frame_o,
    output logic                   out_err_o
);

    // Reset image of the presented frame: lanes all ones, count/checksum zero.
    localparam lane_frame_t FRAME_RST = '{msb: 8'h00, data: '1, lsb: 8'h00};

    lane_pack_state_t state_r;
    lane_pack_state_t state_nxt_s;
    lane_frame_t      acc_r;
    lane_frame_t      acc_nxt_s;
    logic             acc_err_r;
    logic             acc_err_nxt_s;
    lane_frame_t      frame_r;
    lane_frame_t      frame_nxt_s;
    logic             err_r;
    logic             err_nxt_s;

    logic             accept_s;
    logic             in_range_s;
    logic             lane_hit_s;
    lane_frame_t      beat_s;
    logic             beat_err_s;

    // Apply the current beat (if any) to a copy of the accumulator.
    always_comb begin
        accept_s   = in_valid_i && (state_r == FILL);
        in_range_s = (in_addr_i < IDX_W'(LANES));
        lane_hit_s = accept_s && in_range_s;
        beat_s     = acc_r;
        beat_err_s = acc_err_r | (accept_s & ~in_range_s);
        for (int i = 0; i < int'(LANES_DEF); i++) begin
            beat_s.data[i] = (lane_hit_s && (in_addr_i == IDX_W'(i))) ? in_data_i : acc_r.data[i];
        end
        if (lane_hit_s) begin
            beat_s.msb = sat_inc8(acc_r.msb);
            beat_s.lsb = csum_upd8(acc_r.lsb, in_data_i);
        end else begin
            beat_s.msb = acc_r.msb;
            beat_s.lsb = acc_r.lsb;
        end
    end

    // Next-state and register-load decisions for the FILL/HOLD controller.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        acc_err_nxt_s = acc_err_r;
        frame_nxt_s   = frame_r;
        err_nxt_s     = err_r;
        case (state_r)
            FILL: begin
                if (accept_s && in_last_i) begin
                    frame_nxt_s   = beat_s;
                    err_nxt_s     = beat_err_s;
                    acc_nxt_s     = frame_init();
                    acc_err_nxt_s = 1'b0;
                    state_nxt_s   = HOLD;
                end else if (accept_s) begin
                    acc_nxt_s     = beat_s;
                    acc_err_nxt_s = beat_err_s;
                end else begin
                    acc_nxt_s     = acc_r;
                    acc_err_nxt_s = acc_err_r;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    // Frame stays on the bus after the handshake; only valid and err drop.
                    state_nxt_s   = FILL;
                    acc_nxt_s     = frame_init();
                    acc_err_nxt_s = 1'b0;
                    err_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s   = HOLD;
                end
            end
            default: begin
                state_nxt_s   = FILL;
                acc_nxt_s     = frame_init();
                acc_err_nxt_s = 1'b0;
                frame_nxt_s   = FRAME_RST;
                err_nxt_s     = 1'b0;
            end
        endcase
    end

    // State, accumulator and presented-frame registers; reset drops any frame in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= FILL;
            acc_r     <= frame_init();
            acc_err_r <= 1'b0;
            frame_r   <= FRAME_RST;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            acc_err_r <= acc_err_nxt_s;
            frame_r   <= frame_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign in_ready_o  = (state_r == FILL);
    assign out_valid_o = (state_r == HOLD);
    assign out_frame_o = frame_r;
    assign out_err_o   = err_r;

endmodule
